// File: rtl/nios_fprint_processor1_0_cpu1_oci_dct_packer.sv
// Debug-trace packer: shifts 2-bit trace symbols into 30-bit words and hands
// full or flushed-partial words to the trace store over a valid/ready port.
module nios_fprint_processor1_0_cpu1_oci_dct_packer #(
   parameter int SYM_W = 2,
   parameter int SLOTS = 15,
   parameter int BUF_W = 30,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sym_valid,
   input  logic [SYM_W-1:0] sym_data,
   output logic             sym_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic [BUF_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   input  logic             out_ready,
   output logic [BUF_W-1:0] dct_buffer,
   output logic [CNT_W-1:0] dct_count,
   output logic             test_ending,
   output logic             test_has_ended
);

   typedef enum logic [1:0] {FILL, HOLD, ENDED} state_t;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);

   state_t           state;
   logic             flush_pend;
   logic             accept;
   logic             handshake;
   logic [BUF_W-1:0] packed_buf;
   logic [CNT_W-1:0] packed_cnt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sym_ready = 1'b0;
      case (state)
         FILL:    sym_ready = 1'b1;
         HOLD:    sym_ready = out_ready & ~flush_pend & ~test_ending;
         default: sym_ready = 1'b0;
      endcase
   end

   assign accept     = sym_valid & sym_ready;
   assign handshake  = out_valid & out_ready;
   // Oldest symbol drifts toward the MSB as new ones enter at the bottom.
   assign packed_buf = {dct_buffer[BUF_W-SYM_W-1:0], sym_data};
   assign packed_cnt = dct_count + CNT_W'(1);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= FILL;
         dct_buffer     <= '0;
         dct_count      <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_count      <= '0;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
         flush_pend     <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept && dct_count == LAST_SLOT) begin
                  out_valid  <= 1'b1;
                  out_data   <= packed_buf;
                  out_count  <= FULL_CNT;
                  dct_buffer <= '0;
                  dct_count  <= '0;
                  flush_pend <= flush;
                  state      <= HOLD;
               end else if (flush && (accept || dct_count != '0)) begin
                  out_valid   <= 1'b1;
                  out_data    <= accept ? packed_buf : dct_buffer;
                  out_count   <= accept ? packed_cnt : dct_count;
                  dct_buffer  <= '0;
                  dct_count   <= '0;
                  test_ending <= 1'b1;
                  state       <= HOLD;
               end else if (flush) begin
                  test_has_ended <= 1'b1;
                  state          <= ENDED;
               end else if (accept) begin
                  dct_buffer <= packed_buf;
                  dct_count  <= packed_cnt;
               end
            end

            HOLD: begin
               if (handshake) begin
                  if (test_ending) begin
                     out_valid      <= 1'b0;
                     test_ending    <= 1'b0;
                     test_has_ended <= 1'b1;
                     state          <= ENDED;
                  end else if (flush_pend || flush) begin
                     // A flush arriving on the handshake cycle behaves like one already pending.
                     flush_pend <= 1'b0;
                     if (accept || dct_count != '0) begin
                        out_data    <= accept ? packed_buf : dct_buffer;
                        out_count   <= accept ? packed_cnt : dct_count;
                        dct_buffer  <= '0;
                        dct_count   <= '0;
                        test_ending <= 1'b1;
                     end else begin
                        out_valid      <= 1'b0;
                        test_has_ended <= 1'b1;
                        state          <= ENDED;
                     end
                  end else begin
                     out_valid <= 1'b0;
                     state     <= FILL;
                     if (accept) begin
                        dct_buffer <= packed_buf;
                        dct_count  <= packed_cnt;
                     end
                  end
               end else if (flush && !test_ending) begin
                  flush_pend <= 1'b1;
               end
            end

            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
